phase_step_sequencer: RTL and testbench
=======================================

# phase_step_sequencer

Sequences large phase-offset requests into bounded single-shot steps for the DDSM phase adder. A request carries a total unsigned phase offset. The block splits it into steps of at most `P_MAX_STEP` LSBs and drives the adder's enable, strobe and step-value inputs for each step. A programmable settle interval separates steps so the modulator never sees a phase jump larger than one step.

## Interface
Parameters:
- `P_TOTAL_W`, 20: width of requested total phase offset.
- `P_STEP_W`, 12: width of the step value driven to the phase adder.
- `P_MAX_STEP`, 12'd2048: largest step per strobe, 1..2^P_STEP_W-1.
- `P_SETTLE`, 8: idle cycles between consecutive steps, ≥1.

Ports:
- `i_clk`, in, 1: single clock for the whole block.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_req_valid`, in, 1: request valid.
- `i_req_phase`, in, P_TOTAL_W: total offset, unsigned.
- `o_req_ready`, out, 1: high only in IDLE.
- `i_abort`, in, 1: level; stops the sequence at the next step boundary.
- `o_phaseadjusten`, out, 1: adder enable; a low level re-arms the adder's edge detector.
- `o_phase_strobe`, out, 1: adder strobe; the adder applies the step once per strobe window, on the window's second cycle.
- `o_phaseadd`, out, P_STEP_W: current step value.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-cycle pulse at sequence end.
- `o_aborted`, out, 1: valid with `o_done`; high if the sequence ended by abort.
- `o_remaining`, out, P_TOTAL_W: residual offset not yet issued.

## Operation
- Accept occurs when `i_req_valid` & `o_req_ready` are both high. The residual R is loaded with `i_req_phase` and the FSM goes to LOAD.
- LOAD: step = min(R, P_MAX_STEP) is registered into `o_phaseadd`, and R ← R − step.
  - If the loaded R is 0, go straight to DONE with no strobe; `o_aborted` = 0.
- ARM, 1 cycle: `o_phaseadjusten` = 1, strobe = 0, `o_phaseadd` stable.
- STROBE, exactly 2 cycles: `o_phaseadjusten` = 1, `o_phase_strobe` = 1, `o_phaseadd` stable.
- RELEASE, 1 cycle: enable and strobe both 0. Next state:
  - If R = 0, go to DONE.
  - Else if abort is pending, go to DONE with `o_aborted` = 1.
  - Else go to SETTLE.
- SETTLE: counter runs for P_SETTLE cycles, then returns to LOAD.
- DONE, 1 cycle: `o_done` = 1, then return to IDLE.
- `o_phaseadd` changes only in LOAD. It holds from ARM through RELEASE.
- Abort handling:
  - `i_abort` seen in LOAD…SETTLE sets a sticky abort-pending flag. The flag clears in IDLE.
  - A step already in ARM/STROBE always completes, so a half-applied step is impossible.
  - Abort seen in SETTLE takes effect at the SETTLE exit, which goes to DONE instead of LOAD.
  - Abort in IDLE is ignored.
- `o_remaining` always shows R. On abort, it holds the un-issued residual through DONE.
- A new `i_req_valid` while busy is not accepted. There is no queueing.
- Arithmetic is unsigned. The sum of issued steps equals `i_req_phase` exactly, unless aborted. Phase wrap is the adder's modulo behaviour and is not handled here.

## Timing
- Reset values: `o_req_ready` = 1, state IDLE, all other outputs 0, R = 0.
- Accept to first strobe rising edge: 2 cycles (LOAD, ARM).
- Step period for non-final steps: 5 + P_SETTLE cycles (LOAD, ARM, 2×STROBE, RELEASE, SETTLE).
- Total latency for N = ceil(X / P_MAX_STEP) steps: N·5 + (N−1)·P_SETTLE + 1 (DONE) cycles after accept.
- `o_req_ready` reasserts the cycle after `o_done`, so back-to-back requests are spaced ≥1 IDLE cycle.
- Reset mid-sequence: all outputs return to reset values immediately (async), with no done pulse. The adder sees enable low, which clears its edge history.

## Structure
- Shared package `ddsm_pkg`:
  - State enum: IDLE, LOAD, ARM, STROBE, RELEASE, SETTLE, DONE.
  - Default constants: step width 12, `P_MAX_STEP` default.
- One sub-module, `settle_counter`: a loadable down-counter with a terminal-count flag, reusable for the 2-cycle STROBE window as well.
- The FSM, residual register and min/subtract datapath live in the top level.

## Test plan
Test parameters: `P_MAX_STEP` = 1000, `P_SETTLE` = 4.
- Request 2500: steps 1000, 1000, 500. Strobe windows start 9 cycles apart. `o_done` arrives 24 cycles after accept with `o_aborted` = 0, and `o_remaining` = 0.
- Request 0: no enable or strobe activity. `o_done` arrives 2 cycles after accept.
- Request 1000, exactly one step: single strobe window with `o_phaseadd` = 1000, no SETTLE, and `o_done` at cycle 6.
- Request 3000 with `i_abort` pulsed during the first STROBE: the first step (1000) completes, then DONE with `o_aborted` = 1 and `o_remaining` = 2000. No second strobe occurs.
- Reset asserted during the second STROBE of request 2500: enable, strobe and `o_busy` go to 0 asynchronously. After release, `o_req_ready` = 1 and a new request 700 runs normally.
- `i_req_valid` held high continuously with alternating 1500/300: one accept per sequence, and each accept occurs only in IDLE following `o_done`.

Source files
------------

// File: rtl/ddsm_pkg.sv
// Shared types and default constants for the DDSM phase-step sequencer.
// The state enum is also used by the debug state output.
package ddsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        STROBE,
        RELEASE,
        SETTLE,
        DONE
    } state_t;

    localparam int DEF_TOTAL_W = 20;
    localparam int DEF_STEP_W  = 12;
    localparam int DEF_SETTLE  = 8;
    localparam logic [DEF_STEP_W-1:0] DEF_MAX_STEP = 12'd2048;

    // The adder applies a step on the second cycle of a two-cycle strobe window.
    localparam int STROBE_CYCLES = 2;

endpackage

// File: rtl/phase_step_sequencer_if.sv
// Request handshake and phase-adder drive bundle for phase_step_sequencer.
// Handshake: a request transfers on a rising clock edge where i_req_valid and o_req_ready are both high.
interface phase_step_sequencer_if
    import ddsm_pkg::*;
#(
    parameter int P_TOTAL_W = DEF_TOTAL_W,
    parameter int P_STEP_W  = DEF_STEP_W
);
    logic                 i_req_valid;
    logic [P_TOTAL_W-1:0] i_req_phase;
    logic                 o_req_ready;
    logic                 o_phaseadjusten;
    logic                 o_phase_strobe;
    logic [P_STEP_W-1:0]  o_phaseadd;

    modport master (
        output i_req_valid, i_req_phase,
        input  o_req_ready, o_phaseadjusten, o_phase_strobe, o_phaseadd
    );

    modport slave (
        input  i_req_valid, i_req_phase,
        output o_req_ready, o_phaseadjusten, o_phase_strobe, o_phaseadd
    );
endinterface

// File: rtl/settle_counter.sv
// Loadable down-counter with a terminal-count flag; times both the settle
// gap and the strobe window. Counts down to zero and holds there.
module settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         tc
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = (count_q == '0);
endmodule

// File: rtl/phase_step_sequencer.sv
// Splits a large phase-offset request into bounded single-shot steps and
// drives the DDSM phase adder's enable, strobe and step value for each.
module phase_step_sequencer
    import ddsm_pkg::*;
#(
    parameter int                  P_TOTAL_W  = DEF_TOTAL_W,
    parameter int                  P_STEP_W   = DEF_STEP_W,
    parameter logic [P_STEP_W-1:0] P_MAX_STEP = P_STEP_W'(DEF_MAX_STEP),
    parameter int                  P_SETTLE   = DEF_SETTLE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    phase_step_sequencer_if.slave bus,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic [P_TOTAL_W-1:0]  o_remaining,
    output state_t                o_state
);
    localparam int CNT_W = $clog2(P_SETTLE + 1);
    localparam logic [P_TOTAL_W-1:0] MAX_EXT = P_TOTAL_W'(P_MAX_STEP);

    state_t               state_q, state_d;
    logic [P_TOTAL_W-1:0] r_q, r_d;
    logic [P_STEP_W-1:0]  phaseadd_q, phaseadd_d;
    logic                 pend_q, pend_d;
    logic                 aborted_q, aborted_d;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_value;
    logic                 cnt_tc;
    logic [P_TOTAL_W-1:0] step_ext;
    logic                 abort_now;

    settle_counter #(.W(CNT_W)) u_settle_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .load  (cnt_load),
        .value (cnt_value),
        .tc    (cnt_tc)
    );

    assign step_ext  = (r_q > MAX_EXT) ? MAX_EXT : r_q;
    // An abort arriving on the very cycle a decision is made still counts.
    assign abort_now = pend_q | i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            phaseadd_q <= '0;
            pend_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            phaseadd_q <= phaseadd_d;
            pend_q     <= pend_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        phaseadd_d = phaseadd_q;
        pend_d     = pend_q;
        aborted_d  = aborted_q;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        if (state_q != IDLE && state_q != DONE && i_abort) begin
            pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                pend_d    = 1'b0;
                aborted_d = 1'b0;
                if (bus.i_req_valid) begin
                    r_d     = bus.i_req_phase;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (r_q == '0) begin
                    state_d = DONE;
                end else begin
                    phaseadd_d = step_ext[P_STEP_W-1:0];
                    r_d        = r_q - step_ext;
                    state_d    = ARM;
                end
            end
            ARM: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(STROBE_CYCLES - 1);
                state_d   = STROBE;
            end
            STROBE: begin
                if (cnt_tc) state_d = RELEASE;
            end
            RELEASE: begin
                if (r_q == '0) begin
                    state_d = DONE;
                end else if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(P_SETTLE - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_tc) begin
                    if (abort_now) begin
                        aborted_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All control outputs decode the state register, so async reset clears them at once.
    assign bus.o_req_ready     = (state_q == IDLE);
    assign bus.o_phaseadjusten = (state_q == ARM) || (state_q == STROBE);
    assign bus.o_phase_strobe  = (state_q == STROBE);
    assign bus.o_phaseadd      = phaseadd_q;
    assign o_busy              = (state_q != IDLE);
    assign o_done              = (state_q == DONE);
    assign o_aborted           = (state_q == DONE) && aborted_q;
    assign o_remaining         = r_q;
    assign o_state             = state_q;
endmodule

// File: tb/tb_phase_step_sequencer.sv
// Bench for phase_step_sequencer with P_MAX_STEP = 1000 and P_SETTLE = 4.
// Expected step values are queued at request time and popped at each strobe window start.
module tb_phase_step_sequencer;
    import ddsm_pkg::*;

    localparam int TW = 20;
    localparam int SW = 12;
    localparam int MAX_STEP = 1000;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_abort = 1'b0;
    logic          o_busy, o_done, o_aborted;
    logic [TW-1:0] o_remaining;
    state_t        o_state;

    phase_step_sequencer_if #(.P_TOTAL_W(TW), .P_STEP_W(SW)) bus ();

    phase_step_sequencer #(
        .P_TOTAL_W  (TW),
        .P_STEP_W   (SW),
        .P_MAX_STEP (12'd1000),
        .P_SETTLE   (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_aborted   (o_aborted),
        .o_remaining (o_remaining),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            strobe_w = 0;
    bit            prev_strobe = 1'b0;
    int            step_sum = 0;
    logic [SW-1:0] exp_q[$];
    int            strobe_cyc_q[$];

    // Strobe monitor: pops the scoreboard at every strobe window start.
    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rst_n) begin
                prev_strobe = 1'b0;
                strobe_w = 0;
            end else begin
                if (bus.o_phase_strobe && !prev_strobe) begin
                    strobe_cyc_q.push_back(cyc);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: phaseadd=%0d with no step expected", bus.o_phaseadd);
                    end else begin
                        logic [SW-1:0] e;
                        e = exp_q.pop_front();
                        if (bus.o_phaseadd !== e) begin
                            miscompares++;
                            $display("FAIL step_value: got %0d expected %0d", bus.o_phaseadd, e);
                        end
                    end
                    step_sum += int'(bus.o_phaseadd);
                    vectors++;
                    if (bus.o_phaseadjusten !== 1'b1) begin
                        miscompares++;
                        $display("FAIL enable_in_strobe: got %0b expected 1", bus.o_phaseadjusten);
                    end
                end
                if (bus.o_phase_strobe) begin
                    strobe_w++;
                end else if (prev_strobe) begin
                    vectors++;
                    if (strobe_w != 2) begin
                        miscompares++;
                        $display("FAIL strobe_width: got %0d expected 2", strobe_w);
                    end
                    strobe_w = 0;
                end
                prev_strobe = bus.o_phase_strobe;
            end
        end
    end

    task automatic push_steps(input int x);
        int rem;
        int s;
        rem = x;
        while (rem > 0) begin
            s = (rem > MAX_STEP) ? MAX_STEP : rem;
            exp_q.push_back(SW'(s));
            rem -= s;
        end
    endtask

    // Drives one request from IDLE and follows it to o_done (bounded); ends back in IDLE.
    task automatic run_req(input int x, input int abort_at, output int cycles,
                           output logic ab, output logic [TW-1:0] rem, output bit en_seen);
        cycles = -1;
        ab = 1'bx;
        rem = 'x;
        en_seen = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_phase = TW'(x);
        @(negedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            i_abort = (c == abort_at);
            if (bus.o_phaseadjusten || bus.o_phase_strobe) en_seen = 1'b1;
            if (o_done) begin
                cycles = c;
                ab = o_aborted;
                rem = o_remaining;
                break;
            end
            @(negedge i_clk); #1;
        end
        i_abort = 1'b0;
        @(negedge i_clk); #1;
    endtask

    task automatic test_reset;
        bus.i_req_valid = 1'b0;
        bus.i_req_phase = '0;
        repeat (3) @(negedge i_clk);
        #1;
        vectors++; if (bus.o_req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %0b expected 1", bus.o_req_ready); end
        vectors++; if (o_state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", o_state, IDLE); end
        vectors++; if ({o_busy, o_done, o_aborted, bus.o_phaseadjusten, bus.o_phase_strobe} !== 5'b0) begin
            miscompares++; $display("FAIL rst_flags: got %b expected 00000", {o_busy, o_done, o_aborted, bus.o_phaseadjusten, bus.o_phase_strobe});
        end
        vectors++; if (bus.o_phaseadd !== '0 || o_remaining !== '0) begin
            miscompares++; $display("FAIL rst_data: got phaseadd=%0d remaining=%0d expected 0 0", bus.o_phaseadd, o_remaining);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
    endtask

    task automatic test_multi_step;
        int cycles; logic ab; logic [TW-1:0] rem; bit en; int c0;
        strobe_cyc_q.delete();
        step_sum = 0;
        c0 = cyc;
        push_steps(2500);
        run_req(2500, 0, cycles, ab, rem, en);
        vectors++; if (cycles != 24) begin miscompares++; $display("FAIL multi_latency: got %0d expected 24", cycles); end
        vectors++; if (ab !== 1'b0) begin miscompares++; $display("FAIL multi_aborted: got %b expected 0", ab); end
        vectors++; if (rem !== '0) begin miscompares++; $display("FAIL multi_remaining: got %0d expected 0", rem); end
        vectors++; if (step_sum != 2500) begin miscompares++; $display("FAIL multi_sum: got %0d expected 2500", step_sum); end
        vectors++;
        if (strobe_cyc_q.size() != 3) begin
            miscompares++; $display("FAIL multi_windows: got %0d expected 3", strobe_cyc_q.size());
        end else if (strobe_cyc_q[0] - c0 != 3 || strobe_cyc_q[1] - strobe_cyc_q[0] != 9 || strobe_cyc_q[2] - strobe_cyc_q[1] != 9) begin
            miscompares++; $display("FAIL multi_spacing: got %0d,%0d,%0d expected 3,9,9", strobe_cyc_q[0] - c0,
                                    strobe_cyc_q[1] - strobe_cyc_q[0], strobe_cyc_q[2] - strobe_cyc_q[1]);
        end
    endtask

    task automatic test_zero;
        int cycles; logic ab; logic [TW-1:0] rem; bit en;
        strobe_cyc_q.delete();
        run_req(0, 0, cycles, ab, rem, en);
        vectors++; if (cycles != 2) begin miscompares++; $display("FAIL zero_latency: got %0d expected 2", cycles); end
        vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL zero_activity: got %b expected 0", en); end
        vectors++; if (ab !== 1'b0) begin miscompares++; $display("FAIL zero_aborted: got %b expected 0", ab); end
    endtask

    task automatic test_single;
        int cycles; logic ab; logic [TW-1:0] rem; bit en;
        strobe_cyc_q.delete();
        push_steps(1000);
        run_req(1000, 0, cycles, ab, rem, en);
        vectors++; if (cycles != 6) begin miscompares++; $display("FAIL single_latency: got %0d expected 6", cycles); end
        vectors++; if (strobe_cyc_q.size() != 1) begin miscompares++; $display("FAIL single_windows: got %0d expected 1", strobe_cyc_q.size()); end
        vectors++; if (rem !== '0) begin miscompares++; $display("FAIL single_remaining: got %0d expected 0", rem); end
    endtask

    task automatic test_abort;
        int cycles; logic ab; logic [TW-1:0] rem; bit en;
        strobe_cyc_q.delete();
        exp_q.push_back(SW'(1000));
        run_req(3000, 3, cycles, ab, rem, en);
        vectors++; if (cycles != 6) begin miscompares++; $display("FAIL abort_latency: got %0d expected 6", cycles); end
        vectors++; if (ab !== 1'b1) begin miscompares++; $display("FAIL abort_flag: got %b expected 1", ab); end
        vectors++; if (rem !== TW'(2000)) begin miscompares++; $display("FAIL abort_remaining: got %0d expected 2000", rem); end
        vectors++; if (strobe_cyc_q.size() != 1) begin miscompares++; $display("FAIL abort_windows: got %0d expected 1", strobe_cyc_q.size()); end
    endtask

    task automatic test_reset_mid;
        int cycles; logic ab; logic [TW-1:0] rem; bit en;
        exp_q.push_back(SW'(1000));
        exp_q.push_back(SW'(1000));
        bus.i_req_valid = 1'b1;
        bus.i_req_phase = TW'(2500);
        @(negedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        repeat (11) @(negedge i_clk);
        #1;
        vectors++; if (bus.o_phase_strobe !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_strobe: got %b expected 1", bus.o_phase_strobe); end
        i_rst_n = 1'b0;
        #1;
        vectors++; if ({bus.o_phaseadjusten, bus.o_phase_strobe, o_busy} !== 3'b000) begin
            miscompares++; $display("FAIL midrst_outputs: got %b expected 000", {bus.o_phaseadjusten, bus.o_phase_strobe, o_busy});
        end
        vectors++; if (bus.o_req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", bus.o_req_ready); end
        @(negedge i_clk); #1;
        i_rst_n = 1'b1;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL midrst_queue: got %0d expected 0", exp_q.size()); end
        push_steps(700);
        run_req(700, 0, cycles, ab, rem, en);
        vectors++; if (cycles != 6) begin miscompares++; $display("FAIL midrst_after_latency: got %0d expected 6", cycles); end
        vectors++; if (rem !== '0 || ab !== 1'b0) begin miscompares++; $display("FAIL midrst_after_end: got rem=%0d ab=%b expected 0 0", rem, ab); end
    endtask

    task automatic test_back_to_back;
        int  n_acc = 0;
        int  n_done = 0;
        bit  first = 1'b1;
        bit  prev_done = 1'b0;
        bit  just_acc = 1'b0;
        bit  finished = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_phase = TW'(1500);
        for (int c = 0; c < 400 && !finished; c++) begin
            if (just_acc) begin
                just_acc = 1'b0;
                bus.i_req_phase = (bus.i_req_phase == TW'(1500)) ? TW'(300) : TW'(1500);
                if (n_acc == 4) bus.i_req_valid = 1'b0;
            end
            if (o_done) n_done++;
            if (bus.o_req_ready && bus.i_req_valid) begin
                vectors++;
                if (!(first || prev_done)) begin
                    miscompares++; $display("FAIL b2b_accept_timing: accept %0d not right after done", n_acc);
                end
                push_steps(int'(bus.i_req_phase));
                n_acc++;
                just_acc = 1'b1;
                first = 1'b0;
            end
            if (n_done == 4) finished = 1'b1;
            prev_done = o_done;
            @(negedge i_clk); #1;
        end
        bus.i_req_valid = 1'b0;
        vectors++; if (n_acc != 4 || n_done != 4) begin miscompares++; $display("FAIL b2b_counts: got acc=%0d done=%0d expected 4 4", n_acc, n_done); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_queue: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_multi_step();
        test_zero();
        test_single();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
